// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU sharing arbiter: opcode and word types, arbiter
// state encoding, and the round-robin pointer helper.
package alu_share_arbiter_pkg;

    localparam int unsigned ARB_MAX_REQ = 4;
    localparam int unsigned XLEN        = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Index following idx, wrapping from n-1 back to 0.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester found searching
// upward from the pointer, wrapping modulo NREQ.
module alu_share_arbiter_rr_pick #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    // Scan p, p+1, ... and latch onto the first valid entry.
    always_comb begin
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = IDX_W'((32'(ptr) + i) % NREQ);
            if (!any && valid[idx]) begin
                any        = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NREQ requesters. One operation
// in flight: accept (IDLE), drive the ALU from the operand register (EXEC),
// hold the captured result until the granted requester takes it (RESP).
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned WORD_W = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0][3:0]         req_opcode,
    input  logic [NREQ-1:0][WORD_W-1:0]  req_op1,
    input  logic [NREQ-1:0][WORD_W-1:0]  req_op2,
    input  logic [NREQ-1:0][4:0]         req_shamt,
    output logic [NREQ-1:0]              rsp_valid,
    input  logic [NREQ-1:0]              rsp_ready,
    output logic [WORD_W-1:0]            rsp_res,
    output logic                         rsp_flag_v,
    output logic                         rsp_flag_n,
    output logic                         rsp_flag_z,
    output logic [3:0]                   alu_opcode,
    output logic [WORD_W-1:0]            alu_op1,
    output logic [WORD_W-1:0]            alu_op2,
    output logic [4:0]                   alu_shamt,
    input  logic [WORD_W-1:0]            alu_res,
    input  logic                         alu_flag_v,
    input  logic                         alu_flag_n,
    input  logic                         alu_flag_z,
    output logic                         busy
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  gnt_q;

    aluop_t            opcode_q;
    logic [WORD_W-1:0] op1_q;
    logic [WORD_W-1:0] op2_q;
    logic [4:0]        shamt_q;

    logic [WORD_W-1:0] res_q;
    logic              flag_v_q;
    logic              flag_n_q;
    logic              flag_z_q;
    logic [NREQ-1:0]   rsp_valid_q;

    logic [NREQ-1:0]   pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    alu_share_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid     (req_valid),
        .ptr       (ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Offer the round-robin winner only while idle and not being reset.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !RST) begin
            req_ready = pick_grant;
        end
    end

    // Accept / execute / respond sequencing with registered operands and results.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            opcode_q    <= ALU_ADD;
            op1_q       <= '0;
            op2_q       <= '0;
            shamt_q     <= '0;
            res_q       <= '0;
            flag_v_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        // Unsupported encodings are carried through untouched.
                        opcode_q <= aluop_t'(req_opcode[pick_idx]);
                        op1_q    <= req_op1[pick_idx];
                        op2_q    <= req_op2[pick_idx];
                        shamt_q  <= req_shamt[pick_idx];
                        gnt_q    <= pick_idx;
                        ptr_q    <= IDX_W'(rr_next(32'(pick_idx), NREQ));
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    res_q       <= alu_res;
                    flag_v_q    <= alu_flag_v;
                    flag_n_q    <= alu_flag_n;
                    flag_z_q    <= alu_flag_z;
                    rsp_valid_q <= NREQ'(1) << gnt_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    // Only the granted requester's ready can retire the result.
                    if (rsp_ready[gnt_q]) begin
                        rsp_valid_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= '0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_res    = res_q;
    assign rsp_flag_v = flag_v_q;
    assign rsp_flag_n = flag_n_q;
    assign rsp_flag_z = flag_z_q;

    assign alu_opcode = opcode_q;
    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_shamt  = shamt_q;

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU stub, a cycle-level model of
// the accept/execute/respond rules feeding a scoreboard queue, and a monitor
// that pops and compares on every response handshake.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int NREQ   = 2;
    localparam int WORD_W = 32;

    logic                        CLK = 1'b0;
    logic                        RST;
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][3:0]        req_opcode;
    logic [NREQ-1:0][WORD_W-1:0] req_op1;
    logic [NREQ-1:0][WORD_W-1:0] req_op2;
    logic [NREQ-1:0][4:0]        req_shamt;
    logic [NREQ-1:0]             rsp_valid;
    logic [NREQ-1:0]             rsp_ready;
    logic [WORD_W-1:0]           rsp_res;
    logic                        rsp_flag_v, rsp_flag_n, rsp_flag_z;
    logic [3:0]                  alu_opcode;
    logic [WORD_W-1:0]           alu_op1, alu_op2;
    logic [4:0]                  alu_shamt;
    logic [WORD_W-1:0]           alu_res;
    logic                        alu_flag_v, alu_flag_n, alu_flag_z;
    logic                        busy;

    always #5 CLK = ~CLK;

    alu_share_arbiter #(
        .NREQ   (NREQ),
        .WORD_W (WORD_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_shamt  (req_shamt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .rsp_flag_v (rsp_flag_v),
        .rsp_flag_n (rsp_flag_n),
        .rsp_flag_z (rsp_flag_z),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_shamt  (alu_shamt),
        .alu_res    (alu_res),
        .alu_flag_v (alu_flag_v),
        .alu_flag_n (alu_flag_n),
        .alu_flag_z (alu_flag_z),
        .busy       (busy)
    );

    // Reference ALU in plain arithmetic: {result, v, n, z}.
    function automatic logic [34:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        longint      sa, sb, wide;
        logic [31:0] r;
        logic        v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'h0;
        v  = 1'b0;
        case (op)
            ALU_ADD: begin
                wide = sa + sb;
                r    = 32'(wide);
                v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            ALU_SUB: begin
                wide = sa - sb;
                r    = 32'(wide);
                v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  r = a << sh;
            ALU_SRL:  r = a >> sh;
            ALU_SRA:  r = 32'($signed(a) >>> sh);
            default:  r = 32'h0;
        endcase
        return {r, v, r[31], (r == 32'h0)};
    endfunction

    assign {alu_res, alu_flag_v, alu_flag_n, alu_flag_z} =
        ref_alu(alu_opcode, alu_op1, alu_op2, alu_shamt);

    typedef struct {
        int          req;
        logic [31:0] res;
        logic        v;
        logic        n;
        logic        z;
    } exp_t;

    exp_t            sb_q[$];
    int              glog[$];
    int              total = 0;
    int              bad   = 0;
    int              m_phase = 0;
    int              m_ptr   = 0;
    int              m_g     = 0;
    logic [NREQ-1:0] hs_seen = '0;
    logic [31:0]     last_res[NREQ];
    logic [2:0]      last_flags[NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: who may be accepted, when the response appears, when it retires.
    initial begin : model
        int              w;
        exp_t            e;
        logic [34:0]     o;
        logic [NREQ-1:0] exp_rdy;
        forever begin
            @(negedge CLK);
            hs_seen = req_valid & req_ready;
            if (RST) begin
                check("rst_req_ready", req_ready, 0);
                m_phase = 0;
                m_ptr   = 0;
                sb_q.delete();
            end else begin
                case (m_phase)
                    0: begin
                        w = -1;
                        for (int k = 0; k < NREQ; k++) begin
                            if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                        end
                        exp_rdy = (w >= 0) ? (NREQ'(1) << w) : '0;
                        check("idle_req_ready", req_ready, exp_rdy);
                        check("idle_busy", busy, 0);
                        check("idle_rsp_valid", rsp_valid, 0);
                        if (w >= 0) begin
                            o     = ref_alu(req_opcode[w], req_op1[w], req_op2[w], req_shamt[w]);
                            e.req = w;
                            e.res = o[34:3];
                            e.v   = o[2];
                            e.n   = o[1];
                            e.z   = o[0];
                            sb_q.push_back(e);
                            m_g     = w;
                            m_ptr   = (w + 1) % NREQ;
                            m_phase = 1;
                        end
                    end
                    1: begin
                        check("exec_busy", busy, 1);
                        check("exec_req_ready", req_ready, 0);
                        check("exec_rsp_valid", rsp_valid, 0);
                        m_phase = 2;
                    end
                    default: begin
                        check("resp_busy", busy, 1);
                        check("resp_req_ready", req_ready, 0);
                        check("resp_rsp_valid", rsp_valid, NREQ'(1) << m_g);
                        if (rsp_ready[m_g]) m_phase = 0;
                    end
                endcase
            end
        end
    end

    // Monitor: compare every presented response against the scoreboard head.
    initial begin : monitor
        exp_t e;
        int   idx;
        forever begin
            @(negedge CLK);
            if (!RST && rsp_valid != '0) begin
                idx = 0;
                for (int k = 0; k < NREQ; k++) if (rsp_valid[k]) idx = k;
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = sb_q[0];
                    check("sb_rsp_valid", rsp_valid, NREQ'(1) << e.req);
                    check("sb_rsp_res", rsp_res, e.res);
                    check("sb_rsp_flags", {rsp_flag_v, rsp_flag_n, rsp_flag_z}, {e.v, e.n, e.z});
                    if (rsp_ready[e.req]) begin
                        void'(sb_q.pop_front());
                        glog.push_back(idx);
                        last_res[e.req]   = rsp_res;
                        last_flags[e.req] = {rsp_flag_v, rsp_flag_n, rsp_flag_z};
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
        req_opcode[r] = op;
        req_op1[r]    = a;
        req_op2[r]    = b;
        req_shamt[r]  = sh;
        req_valid[r]  = 1'b1;
    endtask

    task automatic wait_accept(input int r, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!hs_seen[r] && n < 30);
        check({tag, "_accept"}, hs_seen[r], 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(m_phase == 0 && sb_q.size() == 0) && n < 50) begin
            step();
            n++;
        end
        check({tag, "_idle"}, (m_phase == 0 && sb_q.size() == 0), 1);
    endtask

    task automatic check_rst_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_res"}, rsp_res, 0);
        check({tag, "_rsp_flags"}, {rsp_flag_v, rsp_flag_n, rsp_flag_z}, 0);
        check({tag, "_alu_opcode"}, alu_opcode, 0);
        check({tag, "_alu_op1"}, alu_op1, 0);
        check({tag, "_alu_op2"}, alu_op2, 0);
        check({tag, "_alu_shamt"}, alu_shamt, 0);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        RST        = 1'b1;
        req_valid  = '1;
        rsp_ready  = '0;
        req_opcode = '0;
        req_op1    = '0;
        req_op2    = '0;
        req_shamt  = '0;
        for (int r = 0; r < NREQ; r++) begin
            last_res[r]   = '0;
            last_flags[r] = '0;
        end
        step();
        step();
        @(negedge CLK);
        check_rst_vals("init");
        step();
        req_valid = '0;
        RST       = 1'b0;

        // Single add with signed overflow.
        rsp_ready = '1;
        set_req(0, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        wait_accept(0, "t1");
        req_valid[0] = 1'b0;
        wait_idle("t1");
        check("t1_res", last_res[0], 32'h8000_0000);
        check("t1_flags", last_flags[0], 3'b110);

        // Contention from a fresh reset: grants alternate starting at 0.
        RST = 1'b1;
        step();
        RST = 1'b0;
        set_req(0, ALU_SUB, 32'd5, 32'd5, 5'd0);
        set_req(1, ALU_OR, 32'hF0, 32'h0F, 5'd0);
        glog.delete();
        repeat (14) step();
        req_valid = '0;
        wait_idle("t2");
        check("t2_ngrants", (glog.size() >= 4), 1);
        for (int k = 0; k < 4 && k < glog.size(); k++) begin
            check($sformatf("t2_grant%0d", k), glog[k], k % 2);
        end
        check("t2_res0", last_res[0], 32'h0);
        check("t2_flags0", last_flags[0], 3'b001);
        check("t2_res1", last_res[1], 32'hFF);

        // Backpressure on req1 while req0 waits and asserts its own rsp_ready.
        rsp_ready = '0;
        set_req(1, ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
        wait_accept(1, "t3");
        req_valid[1] = 1'b0;
        n = 0;
        while (!rsp_valid[1] && n < 10) begin
            step();
            n++;
        end
        check("t3_rsp_arrive", rsp_valid[1], 1);
        set_req(0, ALU_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 5'd0);
        rsp_ready = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("t3_hold_res", rsp_res, 32'd1);
            check("t3_hold_req_ready", req_ready, 0);
            check("t3_hold_busy", busy, 1);
            check("t3_hold_rsp_valid", rsp_valid, 2'b10);
            step();
        end
        rsp_ready = '1;
        wait_accept(0, "t3b");
        req_valid[0] = 1'b0;
        wait_idle("t3");

        // Shift into the sign bit.
        set_req(0, ALU_SLL, 32'h0000_0001, 32'hDEAD_BEEF, 5'd31);
        wait_accept(0, "t4");
        req_valid[0] = 1'b0;
        wait_idle("t4");
        check("t4_res", last_res[0], 32'h8000_0000);
        check("t4_flags", last_flags[0], 3'b010);

        // Reset while in EXEC: transaction dropped, pointer back to 0.
        set_req(0, ALU_ADD, 32'h1234_5678, 32'h0000_0001, 5'd3);
        wait_accept(0, "t5");
        req_valid = '0;
        RST       = 1'b1;
        step();
        RST = 1'b0;
        set_req(0, ALU_AND, 32'h0000_FFFF, 32'h0000_0F0F, 5'd0);
        set_req(1, ALU_OR, 32'h1, 32'h2, 5'd0);
        @(negedge CLK);
        check_rst_vals("t5");
        step();
        check("t5_grant_after_reset", hs_seen, 2'b01);
        req_valid[0] = 1'b0;
        wait_accept(1, "t5b");
        req_valid[1] = 1'b0;
        wait_idle("t5");

        // Random traffic, random (including wrong-requester) rsp_ready.
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (hs_seen[r]) req_valid[r] = 1'b0;
                if (!req_valid[r]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        set_req(r, 4'($urandom_range(0, 15)), rand_word(), rand_word(),
                                5'($urandom_range(0, 31)));
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[r] = 1'b0;
                end
            end
            rsp_ready = NREQ'($urandom);
            step();
        end
        req_valid = '0;
        rsp_ready = '1;
        wait_idle("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
